pll_phase_ctrl: RTL
===================

Name: pll_phase_ctrl

Overview:
- Sequences dynamic fine-phase adjustment of the PLL hard macro on clkout0..clkout4.
- Accepts a step request (channel, direction, step count) over a valid/ready handshake and drives PHASE_SEL, PHASE_DIR and PHASE_STEP_N with the required setup, pulse and gap timing.
- Waits for LOCK after each step and keeps a signed phase position per channel for calibration logic, e.g. the DDR/ADC capture eye search.

Parameters:
- SETUP_CYC, 4, cycles phase_sel/phase_dir are held stable before the first step pulse
- PULSE_CYC, 2, cycles phase_step_n is held low per step
- GAP_CYC, 8, cycles phase_step_n is held high after each pulse, before the lock check
- LOCK_TO, 1024, maximum cycles to wait for pll_lock after a step before an error is flagged
- STEP_W, 8, width of the request step count
- POS_W, 10, width of each signed per-channel position register

Ports:
- clk  in  1  control clock; the free-running PLL reference clock, not a PLL output
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  step request valid
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- req_sel  in  3  target channel, 0..4; values 5..7 are illegal
- req_dir  in  1  1 = advance phase (+), 0 = retard (-)
- req_steps  in  STEP_W  number of steps; 0 is legal
- pll_lock  in  1  PLL LOCK
- phase_sel  out  3  to PLL PHASE_SEL
- phase_dir  out  1  to PLL PHASE_DIR
- phase_step_n  out  1  to PLL PHASE_STEP_N, active low
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when a request completes, including error and illegal completions
- err  out  1  sticky; set on lock timeout or illegal req_sel; cleared on the next accepted request
- rd_sel  in  3  selects the channel to report on rd_pos
- rd_pos  out  POS_W  signed accumulated steps for channel rd_sel; combinational read, 0 for rd_sel > 4

Behaviour:
- Reset values: req_ready=0, phase_sel=0, phase_dir=0, phase_step_n=1, busy=0, done=0, err=0, all positions=0, state IDLE.
- req_ready=1 only in IDLE and only while pll_lock=1. Requests are not queued.
- Acceptance latches sel, dir and steps, and clears err.
- States and transitions:
  - IDLE: on accept, go to SETUP. If req_sel>4, instead set err, pulse done next cycle and stay in IDLE. If steps=0, pulse done next cycle with no pin activity.
  - SETUP: drive phase_sel/phase_dir from the latched request, count SETUP_CYC, then go to PULSE.
  - PULSE: phase_step_n=0 for PULSE_CYC cycles. On leaving, update pos[sel] by +1 or -1 and decrement the remaining-step count. Then go to GAP.
  - GAP: phase_step_n=1 for GAP_CYC cycles, then go to LOCKW.
  - LOCKW: when pll_lock=1, go to PULSE if steps remain, else to FIN. If LOCK_TO cycles elapse without lock, set err and go to FIN with the remaining steps abandoned.
  - FIN: pulse done for one cycle, return to IDLE.
- phase_sel/phase_dir change only in IDLE→SETUP. They hold their values through IDLE afterwards.
- Position arithmetic is two's-complement and saturates at +2^(POS_W-1)-1 and -2^(POS_W-1). On saturation the pin pulse is still issued; only the counter clips.
- Timing for an N-step request:
  - first phase_step_n falling edge occurs SETUP_CYC cycles after acceptance;
  - step-to-step spacing is PULSE_CYC+GAP_CYC+lock-wait cycles (minimum 1 lock-check cycle).
- Lock loss mid-operation does not abort the FSM; only LOCKW checks lock.
- rst asserted in any state: immediate return to reset values on the next edge. phase_step_n returns to 1 the same edge, so no truncated pulse is extended.
- Counters are sized with $clog2 of the largest of SETUP_CYC, PULSE_CYC, GAP_CYC and LOCK_TO.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - state enum {IDLE, SETUP, PULSE, GAP, LOCKW, FIN};
  - NUM_PHASE_CH=5;
  - the default SETUP_CYC, PULSE_CYC, GAP_CYC and LOCK_TO constants.
- One natural sub-module, pll_phase_pos: the five saturating signed up/down position registers with the rd_sel read mux.
- The timing FSM and its down-counter stay in pll_phase_ctrl.

Test Plan:
- Reset, then pll_lock=1, request sel=1 dir=1 steps=3 → phase_sel=1, phase_dir=1; exactly 3 low pulses of 2 cycles each; first falling edge 4 cycles after accept; done once; rd_sel=1 gives rd_pos=+3; err=0.
- Request sel=1 dir=0 steps=5 after the previous test → 5 pulses; rd_pos(1)=-2; rd_pos(0)=0.
- pll_lock forced 0 after the 2nd pulse of a steps=4 request → err=1 exactly LOCK_TO cycles into LOCKW; done pulses; rd_pos changed by exactly 2; req_ready stays 0 until lock returns.
- Request steps=0, then separately sel=6 → each completes with no phase_step_n activity and a done pulse. Only the sel=6 case sets err=1. A subsequent legal request clears err.
- rst asserted during PULSE → phase_step_n=1 and busy=0 on the next edge; all rd_pos=0; req_ready=1 once lock is high.
- POS_W=4: 10 advance steps on channel 4 → 10 pulses observed; rd_pos(4) saturates at +7.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing constants for the PLL
// fine-phase step controller.
package pll_ctrl_pkg;

    localparam int NUM_PHASE_CH = 5;

    localparam int DEF_SETUP_CYC = 4;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_GAP_CYC   = 8;
    localparam int DEF_LOCK_TO   = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        LOCKW = 3'd4,
        FIN   = 3'd5
    } state_e;

    function automatic int max_of4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Step-request handshake between calibration logic and the
// phase-step sequencer.
interface pll_phase_ctrl_if #(
    parameter int STEP_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_sel;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;

    modport master (
        output req_valid,
        output req_sel,
        output req_dir,
        output req_steps,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  req_dir,
        input  req_steps,
        output req_ready
    );

endinterface

// File: rtl/pll_phase_pos.sv
// Per-channel saturating signed phase position registers with
// a combinational read port.
module pll_phase_pos
    import pll_ctrl_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd,
    input  logic [2:0]              upd_sel,
    input  logic                    upd_dir,
    input  logic [2:0]              rd_sel,
    output logic signed [POS_W-1:0] rd_pos
);

    localparam logic signed [POS_W-1:0] POS_MAX =
        {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN =
        {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    logic signed [POS_W-1:0] pos_q [NUM_PHASE_CH];
    logic signed [POS_W-1:0] pos_d [NUM_PHASE_CH];

    // The pin pulse is issued regardless; only the count clips.
    always_comb begin
        for (int i = 0; i < NUM_PHASE_CH; i++) begin
            pos_d[i] = pos_q[i];
            if (upd && upd_sel == 3'(i)) begin
                if (upd_dir) begin
                    if (pos_q[i] != POS_MAX)
                        pos_d[i] = pos_q[i] + POS_ONE;
                end else begin
                    if (pos_q[i] != POS_MIN)
                        pos_d[i] = pos_q[i] - POS_ONE;
                end
            end
        end
    end

    always_comb begin
        rd_pos = '0;
        for (int i = 0; i < NUM_PHASE_CH; i++) begin
            if (rd_sel == 3'(i))
                rd_pos = pos_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PHASE_CH; i++) begin
            if (rst)
                pos_q[i] <= '0;
            else
                pos_q[i] <= pos_d[i];
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for PLL dynamic fine-phase steps: setup, step pulse,
// gap and lock wait per step, with per-channel position tracking.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int LOCK_TO   = DEF_LOCK_TO,
    parameter int STEP_W    = 8,
    parameter int POS_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    pll_phase_ctrl_if.slave         req,
    input  logic                    pll_lock,
    output logic [2:0]              phase_sel,
    output logic                    phase_dir,
    output logic                    phase_step_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [2:0]              rd_sel,
    output logic signed [POS_W-1:0] rd_pos
);

    localparam int MAX_CYC =
        max_of4(SETUP_CYC, PULSE_CYC, GAP_CYC, LOCK_TO);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [2:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              step_n_q, step_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              cnt_zero;
    logic              pos_upd;

    assign req.req_ready = (state_q == IDLE) && pll_lock && !rst;
    assign accept        = req.req_valid && req.req_ready;
    assign cnt_zero      = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        steps_d = steps_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pos_upd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (req.req_sel >= 3'(NUM_PHASE_CH)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req.req_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        sel_d   = req.req_sel;
                        dir_d   = req.req_dir;
                        steps_d = req.req_steps;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    pos_upd = 1'b1;
                    steps_d = steps_q - STEP_W'(1);
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = LOCKW;
                    cnt_d   = CNT_W'(LOCK_TO - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOCKW: begin
                // Lock seen on the last allowed cycle still wins.
                if (pll_lock) begin
                    if (steps_q != '0) begin
                        state_d = PULSE;
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                    end else begin
                        state_d = FIN;
                    end
                end else if (cnt_zero) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == FIN)
            done_d = 1'b1;
        step_n_d = (state_d != PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            steps_q  <= '0;
            sel_q    <= '0;
            dir_q    <= 1'b0;
            step_n_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            step_n_q <= step_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign phase_sel    = sel_q;
    assign phase_dir    = dir_q;
    assign phase_step_n = step_n_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;

    pll_phase_pos #(
        .POS_W(POS_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .upd    (pos_upd),
        .upd_sel(sel_q),
        .upd_dir(dir_q),
        .rd_sel (rd_sel),
        .rd_pos (rd_pos)
    );

endmodule
